btn_click_decoder: RTL and testbench



---
 rtl/btn_pkg.sv | 27 ++
 rtl/btn_click_decoder_if.sv | 34 +++
 rtl/btn_window_timer.sv | 40 ++++
 rtl/btn_click_decoder.sv | 120 ++++++++++++
 tb/tb_btn_click_decoder.sv | 128 ++++++++++++
 5 files changed

// File: rtl/btn_pkg.sv
// Shared types and constants for the button click decoder.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package btn_pkg;

   // Decoder FSM encoding; values are fixed so state can be probed by other logic.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      EMIT = 2'd2
   } state_t;

   // 300 ms at 100 MHz.
   localparam int DEFAULT_WINDOW_CYC = 30_000_000;

   // Largest gesture that can be classified; also the default close-early count.
   localparam int MAX_CLICKS_LIMIT = 3;

   // Click counter width is fixed at 2 bits because a gesture holds at most 3 clicks.
   typedef logic [1:0] click_cnt_t;

   // Next click count; saturation is guaranteed by the FSM forcing EMIT at the limit.
   function automatic click_cnt_t next_click(input click_cnt_t cnt);
      return cnt + 2'd1;
   endfunction

endpackage

// File: rtl/btn_click_decoder_if.sv
// Pulse-in / event-out bundle between a debouncer, the click decoder and its consumers.
// Latency: n/a (signal grouping only).
// Backpressure: none; the input pulse and all event outputs are fire-and-forget.
interface btn_click_decoder_if;
   import btn_pkg::*;

   logic       i_btn_pulse;
   logic       o_single;
   logic       o_double;
   logic       o_triple;
   logic       o_busy;
   click_cnt_t o_click_cnt;

   // Pulse source and event consumer side.
   modport master (
      output i_btn_pulse,
      input  o_single,
      input  o_double,
      input  o_triple,
      input  o_busy,
      input  o_click_cnt
   );

   // Decoder side.
   modport slave (
      input  i_btn_pulse,
      output o_single,
      output o_double,
      output o_triple,
      output o_busy,
      output o_click_cnt
   );

endinterface

// File: rtl/btn_window_timer.sv
// Gesture window timer: counts idle cycles since the last accepted pulse.
// Latency: expire is combinational from the registered count (fires on the cycle cnt==WINDOW_CYC-1).
// Backpressure: none; clear dominates run, and the count sits at 0 whenever run is low.
module btn_window_timer #(
   parameter int WINDOW_CYC = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic expire
);

   localparam int                 CNT_W = (WINDOW_CYC > 2) ? $clog2(WINDOW_CYC) : 1;
   localparam logic [CNT_W-1:0]   LAST  = CNT_W'(WINDOW_CYC - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Count only while running; any clear or stop returns the counter to 0,
   // so it can never pass LAST and wrap.
   always_comb begin
      cnt_d = '0;
      if (run && !clear) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire = run && (cnt_q == LAST);

endmodule

// File: rtl/btn_click_decoder.sv
// Groups debounced press pulses into single/double/triple click gestures, one event per gesture.
// Latency: event asserts WINDOW_CYC cycles after the last pulse, or the cycle after the MAX_CLICKS-th pulse.
// Backpressure: none; a pulse landing in the emit cycle opens a new gesture so nothing is dropped.
module btn_click_decoder
   import btn_pkg::*;
#(
   parameter int WINDOW_CYC = DEFAULT_WINDOW_CYC,
   parameter int MAX_CLICKS = MAX_CLICKS_LIMIT
) (
   input  logic                clk,
   input  logic                rst,
   btn_click_decoder_if.slave  bus
);

   localparam click_cnt_t MAX_CNT   = click_cnt_t'(MAX_CLICKS);
   localparam logic       HAS_TRIPLE = (MAX_CLICKS >= 3);

   state_t     state_q,  state_d;
   click_cnt_t clicks_q, clicks_d;
   click_cnt_t clicks_inc;
   logic       single_q, single_d;
   logic       double_q, double_d;
   logic       triple_q, triple_d;
   logic       busy_q,   busy_d;

   logic       pulse;
   logic       timer_run;
   logic       timer_clear;
   logic       timer_expire;

   assign pulse      = bus.i_btn_pulse;
   assign clicks_inc = next_click(clicks_q);

   // The window only runs in WAIT; it restarts on every accepted pulse and on
   // expiry so the counter is already 0 when the FSM moves to EMIT.
   assign timer_run   = (state_q == WAIT);
   assign timer_clear = pulse || timer_expire;

   btn_window_timer #(
      .WINDOW_CYC (WINDOW_CYC)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (timer_clear),
      .run    (timer_run),
      .expire (timer_expire)
   );

   // Next state and click count; a pulse always takes priority over a timeout.
   always_comb begin
      state_d  = state_q;
      clicks_d = clicks_q;
      unique case (state_q)
         IDLE: begin
            if (pulse) begin
               state_d  = WAIT;
               clicks_d = 2'd1;
            end
         end
         WAIT: begin
            if (pulse) begin
               clicks_d = clicks_inc;
               if (clicks_inc == MAX_CNT) begin
                  state_d = EMIT;
               end
            end else if (timer_expire) begin
               state_d = EMIT;
            end
         end
         EMIT: begin
            if (pulse) begin
               state_d  = WAIT;
               clicks_d = 2'd1;
            end else begin
               state_d  = IDLE;
               clicks_d = 2'd0;
            end
         end
         default: begin
            state_d  = IDLE;
            clicks_d = 2'd0;
         end
      endcase
   end

   // Event/status outputs are precomputed from the next state so that, once
   // registered, they are a pure decode of state/count with no glitches.
   always_comb begin
      single_d = (state_d == EMIT) && (clicks_d == 2'd1);
      double_d = (state_d == EMIT) && (clicks_d == 2'd2);
      triple_d = HAS_TRIPLE && (state_d == EMIT) && (clicks_d == 2'd3);
      busy_d   = (state_d != IDLE);
   end

   // FSM, click count and registered outputs; reset aborts any open gesture.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         clicks_q <= 2'd0;
         single_q <= 1'b0;
         double_q <= 1'b0;
         triple_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         clicks_q <= clicks_d;
         single_q <= single_d;
         double_q <= double_d;
         triple_q <= triple_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.o_single    = single_q;
   assign bus.o_double    = double_q;
   assign bus.o_triple    = triple_q;
   assign bus.o_busy      = busy_q;
   assign bus.o_click_cnt = clicks_q;

endmodule

// File: tb/tb_btn_click_decoder.sv
// Directed bench for btn_click_decoder with WINDOW_CYC=10, MAX_CLICKS=3.
// Latency: each scenario runs a fixed 31-edge window after reset.
// Backpressure: n/a.
module tb_btn_click_decoder;
   import btn_pkg::*;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   btn_click_decoder_if bif ();

   btn_click_decoder #(
      .WINDOW_CYC (10),
      .MAX_CLICKS (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its expectation and log a mismatch.
   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Bit mask with bits lo..hi set (inclusive).
   function automatic logic [31:0] rng(input int lo, input int hi);
      logic [31:0] m;
      m = '0;
      for (int i = lo; i <= hi; i++) m[i] = 1'b1;
      return m;
   endfunction

   function automatic logic [31:0] bt(input int e);
      logic [31:0] m;
      m = '0;
      m[e] = 1'b1;
      return m;
   endfunction

   // Packed view: {single, double, triple, busy, click_cnt[1:0]}.
   function automatic logic [31:0] obs_vec();
      return {26'd0, bif.o_single, bif.o_double, bif.o_triple, bif.o_busy, bif.o_click_cnt};
   endfunction

   // Resets the DUT (edge 0 is the last reset edge), then for edges 1..31 drives
   // the pulse/reset masks before the edge and checks outputs 1 time unit after it.
   task automatic run_scn(input string name,
                          input logic [31:0] pulse_m, input logic [31:0] rst_m,
                          input logic [31:0] s_m, input logic [31:0] d_m, input logic [31:0] t_m,
                          input logic [31:0] busy_m,
                          input logic [31:0] c1_m, input logic [31:0] c2_m, input logic [31:0] c3_m);
      logic [1:0]  ecnt;
      logic [31:0] exp;
      bif.i_btn_pulse = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_eq($sformatf("%s reset", name), obs_vec(), 32'd0);
      rst = 1'b0;
      for (int e = 1; e <= 31; e++) begin
         bif.i_btn_pulse = pulse_m[e];
         rst             = rst_m[e];
         @(posedge clk);
         #1;
         ecnt = c3_m[e] ? 2'd3 : c2_m[e] ? 2'd2 : c1_m[e] ? 2'd1 : 2'd0;
         exp  = {26'd0, s_m[e], d_m[e], t_m[e], busy_m[e], ecnt};
         check_eq($sformatf("%s e%0d", name, e), obs_vec(), exp);
      end
      bif.i_btn_pulse = 1'b0;
      rst = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      bif.i_btn_pulse = 1'b0;

      // Single click: timeout 10 edges after the pulse.
      run_scn("single", bt(5), '0,
              bt(15), '0, '0, rng(5, 15),
              rng(5, 15), '0, '0);

      // Double click closed by timeout after the second pulse.
      run_scn("double", bt(5) | bt(12), '0,
              '0, bt(22), '0, rng(5, 22),
              rng(5, 11), rng(12, 22), '0);

      // Triple click closes immediately on the third pulse.
      run_scn("triple", bt(5) | bt(8) | bt(11), '0,
              '0, '0, bt(11), rng(5, 11),
              rng(5, 7), rng(8, 10), bt(11));

      // Second pulse on the timeout edge: pulse wins, window restarts.
      run_scn("coincide", bt(5) | bt(15), '0,
              '0, bt(25), '0, rng(5, 25),
              rng(5, 14), rng(15, 25), '0);

      // Pulse in the emit cycle opens a new gesture.
      run_scn("emit_pulse", bt(5) | bt(16), '0,
              bt(15) | bt(26), '0, '0, rng(5, 26),
              rng(5, 26), '0, '0);

      // Reset mid-gesture aborts it; a later pulse starts fresh.
      run_scn("rst_wait", bt(5) | bt(7) | bt(12), bt(9),
              bt(22), '0, '0, rng(5, 8) | rng(12, 22),
              rng(5, 6) | rng(12, 22), rng(7, 8), '0);

      // Reset on the emit edge suppresses the event.
      run_scn("rst_emit", bt(5), bt(15),
              '0, '0, '0, rng(5, 14),
              rng(5, 14), '0, '0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
